// File: rtl/naes_ctrl_pkg.sv
// Shared types for the NES joypad port: button bit positions, scanner states and the d-pad mask helper.
package naes_ctrl_pkg;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LATCH  = 3'd1,
    CLK_LO = 3'd2,
    CLK_HI = 3'd3,
    DONE   = 3'd4
  } scan_state_t;

  typedef logic [7:0] buttons_t;

  // Opposing directions pressed together are physically impossible; drop both of each pair.
  function automatic buttons_t dpad_mask(input buttons_t b);
    buttons_t m;
    m = b;
    if (b[BTN_UP] && b[BTN_DOWN]) begin
      m[BTN_UP]   = 1'b0;
      m[BTN_DOWN] = 1'b0;
    end else begin
      m[BTN_UP]   = b[BTN_UP];
      m[BTN_DOWN] = b[BTN_DOWN];
    end
    if (b[BTN_LEFT] && b[BTN_RIGHT]) begin
      m[BTN_LEFT]  = 1'b0;
      m[BTN_RIGHT] = 1'b0;
    end else begin
      m[BTN_LEFT]  = b[BTN_LEFT];
      m[BTN_RIGHT] = b[BTN_RIGHT];
    end
    return m;
  endfunction

endpackage

// File: rtl/pad_scanner.sv
// Periodic NES pad scanner: poll timer plus latch/clock FSM that samples the serial pad into 8 bits.
// done is high for the single DONE cycle, when sampled holds the complete new scan.
module pad_scanner
  import naes_ctrl_pkg::*;
#(
  parameter int HALF_PERIOD = 300,
  parameter int POLL_PERIOD = 833333
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     pad_data,
  output logic     pad_latch,
  output logic     pad_clk,
  output buttons_t sampled,
  output logic     done
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_PERIOD - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);

  scan_state_t   state_r;
  logic [PW-1:0] poll_cnt_r;
  logic [HW-1:0] half_cnt_r;
  logic [2:0]    bit_cnt_r;
  buttons_t      sample_r;
  logic          pad_latch_r;
  logic          pad_clk_r;
  logic          done_r;
  logic          poll_wrap_s;
  logic          half_last_s;

  assign poll_wrap_s = (poll_cnt_r == POLL_LAST);
  assign half_last_s = (half_cnt_r == HALF_LAST);

  // Poll timer and scan FSM; pad pins are driven straight from registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      poll_cnt_r  <= '0;
      half_cnt_r  <= '0;
      bit_cnt_r   <= 3'd0;
      sample_r    <= 8'h00;
      pad_latch_r <= 1'b0;
      pad_clk_r   <= 1'b1;
      done_r      <= 1'b0;
    end else begin
      poll_cnt_r <= poll_wrap_s ? '0 : poll_cnt_r + PW'(1);
      done_r     <= 1'b0;
      case (state_r)
        IDLE: begin
          if (poll_wrap_s) begin
            state_r     <= LATCH;
            half_cnt_r  <= '0;
            pad_latch_r <= 1'b1;
          end
        end
        LATCH: begin
          if (half_last_s) begin
            sample_r[0] <= ~pad_data;
            bit_cnt_r   <= 3'd1;
            half_cnt_r  <= '0;
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b0;
            state_r     <= CLK_LO;
          end else begin
            half_cnt_r <= half_cnt_r + HW'(1);
          end
        end
        CLK_LO: begin
          if (half_last_s) begin
            half_cnt_r <= '0;
            pad_clk_r  <= 1'b1;
            state_r    <= CLK_HI;
          end else begin
            half_cnt_r <= half_cnt_r + HW'(1);
          end
        end
        CLK_HI: begin
          if (half_last_s) begin
            sample_r[bit_cnt_r] <= ~pad_data;
            half_cnt_r          <= '0;
            if (bit_cnt_r == 3'd7) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              pad_clk_r <= 1'b0;
              state_r   <= CLK_LO;
            end
          end else begin
            half_cnt_r <= half_cnt_r + HW'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          pad_latch_r <= 1'b0;
          pad_clk_r   <= 1'b1;
        end
      endcase
    end
  end

  assign pad_latch = pad_latch_r;
  assign pad_clk   = pad_clk_r;
  assign sampled   = sample_r;
  assign done      = done_r;

endmodule

// File: rtl/controller_port.sv
// CPU-facing NES joypad register: strobe, serial read shift register and committed button state.
// Optional build macro CTRL_DPAD_MASK_EN clears opposing d-pad pairs before they are committed.
module controller_port
  import naes_ctrl_pkg::*;
#(
  parameter int         HALF_PERIOD = 300,
  parameter int         POLL_PERIOD = 833333,
  parameter logic [6:0] OPEN_BUS    = 7'h20
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       CPU_CE,
  input  logic       EN,
  input  logic       CPU_WR,
  input  logic [7:0] CPU_DO,
  output logic [7:0] DATA_OUT,
  output logic       PAD_LATCH,
  output logic       PAD_CLK,
  input  logic       PAD_DATA,
  output logic [7:0] BUTTONS
);

  buttons_t raw_s;
  buttons_t commit_s;
  buttons_t reload_s;
  buttons_t buttons_r;
  buttons_t sreg_r;
  logic     strobe_r;
  logic     done_s;
  logic     wr_s;
  logic     rd_s;
  logic     unused_s;

  pad_scanner #(
    .HALF_PERIOD (HALF_PERIOD),
    .POLL_PERIOD (POLL_PERIOD)
  ) u_scanner (
    .clk       (Clk),
    .reset     (Reset),
    .pad_data  (PAD_DATA),
    .pad_latch (PAD_LATCH),
    .pad_clk   (PAD_CLK),
    .sampled   (raw_s),
    .done      (done_s)
  );

  assign wr_s     = CPU_CE & EN & ~CPU_WR;
  assign rd_s     = CPU_CE & EN & CPU_WR;
  assign unused_s = ^CPU_DO[7:1];

  // Value committed at the end of a scan; the strobe reload bypasses it so it is seen without a cycle of lag.
  always_comb begin
    commit_s = 8'h00;
    reload_s = 8'h00;
`ifdef CTRL_DPAD_MASK_EN
    commit_s = dpad_mask(raw_s);
`else
    commit_s = raw_s;
`endif
    if (done_s) begin
      reload_s = commit_s;
    end else begin
      reload_s = buttons_r;
    end
  end

  // Button commit, strobe latch and serial shift; a write in the same cycle suppresses the shift.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      buttons_r <= 8'h00;
      sreg_r    <= 8'h00;
      strobe_r  <= 1'b0;
    end else begin
      if (done_s) begin
        buttons_r <= commit_s;
      end
      if (wr_s) begin
        strobe_r <= CPU_DO[0];
      end
      if (strobe_r) begin
        sreg_r <= reload_s;
      end else if (rd_s && !wr_s) begin
        sreg_r <= {1'b1, sreg_r[7:1]};
      end
    end
  end

  assign DATA_OUT = {OPEN_BUS, sreg_r[0]};
  assign BUTTONS  = buttons_r;

endmodule

// File: tb/tb_controller_port.sv
// Directed bench for controller_port with a shift-register pad model and a read-data scoreboard.
module tb_controller_port;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_ce = 1'b0;
  logic       en = 1'b0;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_do = 8'h00;
  logic [7:0] data_out;
  logic       pad_latch;
  logic       pad_clk;
  logic       pad_data;
  logic [7:0] buttons;

  logic [7:0] pad_vec = 8'hFF;
  logic [7:0] pad_shift = 8'hFF;
  logic       pad_clk_q = 1'b1;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] exp_q[$];

  controller_port #(
    .HALF_PERIOD (2),
    .POLL_PERIOD (64),
    .OPEN_BUS    (7'h20)
  ) dut (
    .Clk       (clk),
    .Reset     (reset),
    .CPU_CE    (cpu_ce),
    .EN        (en),
    .CPU_WR    (cpu_wr),
    .CPU_DO    (cpu_do),
    .DATA_OUT  (data_out),
    .PAD_LATCH (pad_latch),
    .PAD_CLK   (pad_clk),
    .PAD_DATA  (pad_data),
    .BUTTONS   (buttons)
  );

  always #5 clk = ~clk;

  // Pad model: parallel load while latched, shift toward bit 0 on each PAD_CLK rise, ones fill in.
  always @(posedge clk) begin
    pad_clk_q <= pad_clk;
    if (pad_latch) pad_shift <= pad_vec;
    else if (pad_clk && !pad_clk_q) pad_shift <= {1'b1, pad_shift[7:1]};
  end
  assign pad_data = pad_shift[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every CPU read cycle pops one expected byte.
  always @(negedge clk) begin
    if (cpu_ce && en && cpu_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL read_unexpected: got %0h expected none", data_out);
      end else begin
        check("read_data", {24'h0, data_out}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic cpu_write(input logic v);
    @(posedge clk); #1;
    cpu_ce = 1'b1; en = 1'b1; cpu_wr = 1'b0; cpu_do = {7'h00, v};
    @(posedge clk); #1;
    cpu_ce = 1'b0; en = 1'b0;
  endtask

  task automatic cpu_read(input logic [7:0] expv);
    @(posedge clk); #1;
    exp_q.push_back(expv);
    cpu_ce = 1'b1; en = 1'b1; cpu_wr = 1'b1;
    @(posedge clk); #1;
    cpu_ce = 1'b0; en = 1'b0; cpu_wr = 1'b0;
  endtask

  logic [7:0] rd_exp [10] = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41};
  logic [7:0] exp6;
  int n;
  bit found;

  initial begin
`ifdef CTRL_DPAD_MASK_EN
    exp6 = 8'h40;
`else
    exp6 = 8'h70;
`endif
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_latch", {31'h0, pad_latch}, 32'h0);
    check("rst_clk", {31'h0, pad_clk}, 32'h1);
    check("rst_buttons", {24'h0, buttons}, 32'h0);
    check("rst_data_out", {24'h0, data_out}, 32'h40);

    // 1: reset while the pad clock is low
    pad_vec = 8'b1111_0110;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk); #1;
      if (!pad_clk) found = 1'b1;
    end
    check("reach_clk_lo", {31'h0, found}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midscan_latch", {31'h0, pad_latch}, 32'h0);
    check("midscan_clk", {31'h0, pad_clk}, 32'h1);
    check("midscan_buttons", {24'h0, buttons}, 32'h0);
    n = 0;
    for (int i = 1; i <= 200 && n == 0; i++) begin
      @(posedge clk); #1;
      if (pad_latch) n = i;
    end
    check("restart_delay", n, 64);

    // 2: A+Start scan result and scan length from latch rise to commit
    n = 0;
    for (int i = 1; i <= 100 && n == 0; i++) begin
      @(posedge clk); #1;
      if (buttons != 8'h00) n = i;
    end
    check("scan_buttons", {24'h0, buttons}, 32'h09);
    check("scan_length", n, 31);

    // 3: strobe pulse then ten serial reads
    cpu_write(1'b1);
    cpu_write(1'b0);
    for (int i = 0; i < 10; i++) cpu_read(rd_exp[i]);

    // 4: strobe held high, reads keep returning A
    cpu_write(1'b1);
    for (int i = 0; i < 3; i++) cpu_read(8'h41);

    // 5: commit of 8'h02 while strobe is high; read in the first cycle after commit
    pad_vec = 8'hFD;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (buttons == 8'h02) begin
        found = 1'b1;
        exp_q.push_back(8'h40);
        cpu_ce = 1'b1; en = 1'b1; cpu_wr = 1'b1;
        @(posedge clk); #1;
        cpu_ce = 1'b0; en = 1'b0; cpu_wr = 1'b0;
      end
    end
    check("bypass_commit_seen", {31'h0, found}, 32'h1);

    // 6: Up+Down+Left, masked or raw depending on build
    cpu_write(1'b0);
    pad_vec = 8'h8F;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (buttons != 8'h02) found = 1'b1;
    end
    check("dpad_buttons", {24'h0, buttons}, {24'h0, exp6});
    cpu_write(1'b1);
    cpu_write(1'b0);
    for (int i = 0; i < 6; i++) cpu_read({7'h20, exp6[i]});

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
